pipe_reg_elastic: RTL and testbench

Parametrised elastic pipeline register that replaces the fixed stall/flush stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It holds up to DEPTH payload beats in a circular buffer, with a valid/ready handshake on both sides. It supports a synchronous flush, and a 2-entry configuration sustains one beat per cycle with no combinational ready path. Optional saturating performance counters report back-pressure and flush activity.

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/pipe_reg_elastic_sat_counter.sv | 25 ++
 rtl/pipe_reg_elastic.sv | 106 ++++++++++
 tb/tb_pipe_reg_elastic.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: depth limit, perf readout struct and pointer sizing helper.
package pipeline_pkg;

   localparam int PIPE_MAX_DEPTH  = 8;
   localparam int PIPE_PERF_CSR_W = 32;

   typedef struct packed {
      logic [PIPE_PERF_CSR_W-1:0] stall_cnt;
      logic [PIPE_PERF_CSR_W-1:0] flush_cnt;
   } pipe_perf_t;

   // A single-entry buffer still needs a 1-bit pointer to keep the vectors legal.
   function automatic int pipe_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pipe_reg_elastic_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; holds at all-ones.
module sat_counter
   import pipeline_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (inc_i && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic valid/ready pipeline register: DEPTH-entry circular buffer with synchronous flush.
// Define PIPE_REG_PERF_EN to add saturating stall/flush performance counters.
module pipe_reg_elastic
   import pipeline_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   parameter int CNT_W = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [WIDTH-1:0]           data_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [WIDTH-1:0]           data_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef PIPE_REG_PERF_EN
   ,
   output logic [CNT_W-1:0]           stall_cnt_o,
   output logic [CNT_W-1:0]           flush_cnt_o
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = pipe_ptr_w(DEPTH);

   if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH || CNT_W < 1) begin : g_bad_cfg
      $fatal(1, "pipe_reg_elastic: DEPTH must be 1..%0d and CNT_W >= 1", PIPE_MAX_DEPTH);
   end

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;

   logic w_ready;
   logic w_valid;
   logic w_push;
   logic w_pop;

   // ready depends only on occupancy, so ready_i never reaches ready_o combinationally.
   assign w_ready = (r_count != CW'(DEPTH));
   assign w_valid = (r_count != '0);
   assign w_push  = valid_i && w_ready && !flush_i;
   assign w_pop   = w_valid && ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Payload storage is deliberately unreset; the zeroed output when empty hides stale data.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= data_i;
   end

   assign ready_o = w_ready;
   assign valid_o = w_valid;
   assign data_o  = w_valid ? r_mem[r_rd_ptr] : '0;
   assign count_o = r_count;

`ifdef PIPE_REG_PERF_EN
   logic w_stall_inc;
   logic w_flush_inc;

   assign w_stall_inc = w_valid && !ready_i;
   assign w_flush_inc = flush_i && w_valid;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (w_stall_inc),
      .cnt_o  (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (w_flush_inc),
      .cnt_o  (flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench for pipe_reg_elastic at DEPTH 1..4 (counter checks when PIPE_REG_PERF_EN is defined).
`timescale 1ns/1ps
module tb_pipe_reg_elastic;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   pushes;
  int   pops;
  logic exp_rdy;
  logic done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  logic       v1, r1, f1, rdy1, vld1;
  logic [7:0] d1, do1;
  logic [0:0] cnt1;
  logic       v2, r2, f2, rdy2, vld2;
  logic [7:0] d2, do2;
  logic [1:0] cnt2;
  logic       v3, r3, f3, rdy3, vld3;
  logic [7:0] d3, do3;
  logic [1:0] cnt3;
  logic       v4, r4, f4, rdy4, vld4;
  logic [7:0] d4, do4;
  logic [2:0] cnt4;
`ifdef PIPE_REG_PERF_EN
  logic [3:0] st1, fl1, st2, fl2, st3, fl3, st4, fl4;
`endif

  pipe_reg_elastic #(.WIDTH(8), .DEPTH(1), .CNT_W(4)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f1), .valid_i(v1), .ready_o(rdy1), .data_i(d1),
    .valid_o(vld1), .ready_i(r1), .data_o(do1), .count_o(cnt1)
`ifdef PIPE_REG_PERF_EN
    , .stall_cnt_o(st1), .flush_cnt_o(fl1)
`endif
  );

  pipe_reg_elastic #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) u_d2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f2), .valid_i(v2), .ready_o(rdy2), .data_i(d2),
    .valid_o(vld2), .ready_i(r2), .data_o(do2), .count_o(cnt2)
`ifdef PIPE_REG_PERF_EN
    , .stall_cnt_o(st2), .flush_cnt_o(fl2)
`endif
  );

  pipe_reg_elastic #(.WIDTH(8), .DEPTH(3), .CNT_W(4)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f3), .valid_i(v3), .ready_o(rdy3), .data_i(d3),
    .valid_o(vld3), .ready_i(r3), .data_o(do3), .count_o(cnt3)
`ifdef PIPE_REG_PERF_EN
    , .stall_cnt_o(st3), .flush_cnt_o(fl3)
`endif
  );

  pipe_reg_elastic #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f4), .valid_i(v4), .ready_o(rdy4), .data_i(d4),
    .valid_o(vld4), .ready_i(r4), .data_o(do4), .count_o(cnt4)
`ifdef PIPE_REG_PERF_EN
    , .stall_cnt_o(st4), .flush_cnt_o(fl4)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    if (!done) begin
      errors++;
      $error("FAIL timeout: stimulus did not complete");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    rst_n = 1'b0;
    {v1, r1, f1, d1} = '0;
    {v2, r2, f2, d2} = '0;
    {v3, r3, f3, d3} = '0;
    {v4, r4, f4, d4} = '0;
    #2;
    chk("rst_valid", vld2, 1'b0);
    chk("rst_ready", rdy2, 1'b1);
    chk("rst_count", cnt2, 2'd0);
    chk("rst_data", do2, 8'h00);
`ifdef PIPE_REG_PERF_EN
    chk("rst_cnts", {st1, fl1, st2, fl2, st3, fl3, st4, fl4}, 32'h0);
`endif
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Streaming, DEPTH=2
    v2 = 1'b1;
    r2 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      d2 = 8'(i);
      step();
      chk("stream_data", do2, 8'(i));
      chk("stream_ready", rdy2, 1'b1);
    end
    v2 = 1'b0;
    step();
    chk("stream_drain_valid", vld2, 1'b0);
    chk("stream_drain_count", cnt2, 2'd0);
    chk("stream_drain_data", do2, 8'h00);

    // Back-pressure fill and pointer wrap, DEPTH=3
    r3 = 1'b0;
    v3 = 1'b1;
    d3 = 8'hA0;
    step();
    chk("bp_count1", cnt3, 2'd1);
    chk("bp_ready1", rdy3, 1'b1);
    d3 = 8'hA1;
    step();
    d3 = 8'hA2;
    step();
    chk("bp_count3", cnt3, 2'd3);
    chk("bp_full_ready", rdy3, 1'b0);
    d3 = 8'hA3;
    step();
    chk("bp_reject_count", cnt3, 2'd3);
    chk("bp_head", do3, 8'hA0);
    v3 = 1'b0;
    r3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_drain_data", do3, 8'(8'hA0 + i));
      step();
    end
    chk("bp_empty_valid", vld3, 1'b0);
    chk("bp_empty_count", cnt3, 2'd0);
    v3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d3 = 8'(8'hB0 + i);
      step();
      chk("wrap_data", do3, 8'(8'hB0 + i));
    end
    v3 = 1'b0;
    step();
    chk("wrap_empty", vld3, 1'b0);

    // Flush collision, DEPTH=2
    r2 = 1'b0;
    v2 = 1'b1;
    d2 = 8'h11;
    step();
    d2 = 8'h22;
    step();
    chk("fl_count2", cnt2, 2'd2);
    chk("fl_full_ready", rdy2, 1'b0);
    d2 = 8'h55;
    f2 = 1'b1;
    r2 = 1'b1;
    chk("fl_popped_head", do2, 8'h11);
    step();
    f2 = 1'b0;
    v2 = 1'b0;
    r2 = 1'b0;
    chk("fl_count0", cnt2, 2'd0);
    chk("fl_valid0", vld2, 1'b0);
    chk("fl_data0", do2, 8'h00);
    f2 = 1'b1;
    step();
    f2 = 1'b0;
    chk("fl_empty_flush_valid", vld2, 1'b0);
    v2 = 1'b1;
    d2 = 8'h66;
    step();
    v2 = 1'b0;
    chk("fl_after_data", do2, 8'h66);
    chk("fl_after_count", cnt2, 2'd1);
    f2 = 1'b1;
    step();
    f2 = 1'b0;
    chk("fl_second_count", cnt2, 2'd0);
`ifdef PIPE_REG_PERF_EN
    chk("flush_cnt", fl2, 4'd2);
    v2 = 1'b1;
    d2 = 8'h77;
    step();
    v2 = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("stall_cnt_sat", st2, 4'd15);
    chk("stall_head", do2, 8'h77);
`endif

    // DEPTH=1 half-rate throughput
    v1 = 1'b1;
    r1 = 1'b1;
    pushes = 0;
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      d1 = 8'(8'h30 + i);
      exp_rdy = ((i % 2) == 0);
      chk("d1_ready", rdy1, exp_rdy);
      if ((i % 2) == 1) begin
        chk("d1_data", do1, 8'(8'h30 + i - 1));
      end
      if (v1 && rdy1) pushes++;
      if (vld1 && r1) pops++;
      step();
    end
    v1 = 1'b0;
    chk("d1_pushes", pushes, 5);
    chk("d1_pops", pops, 5);
    chk("d1_count", cnt1, 1'b0);

    // Asynchronous reset mid-stream, DEPTH=4
    r4 = 1'b0;
    v4 = 1'b1;
    d4 = 8'h41;
    step();
    d4 = 8'h42;
    step();
    d4 = 8'h43;
    step();
    v4 = 1'b0;
    chk("ar_count3", cnt4, 3'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", vld4, 1'b0);
    chk("ar_count", cnt4, 3'd0);
    chk("ar_ready", rdy4, 1'b1);
    chk("ar_data", do4, 8'h00);
`ifdef PIPE_REG_PERF_EN
    chk("ar_cnts", {st2, fl2}, 8'h00);
`endif
    v4 = 1'b1;
    d4 = 8'h99;
    step();
    chk("ar_push_ignored", cnt4, 3'd0);
    d4 = 8'h77;
    #2;
    rst_n = 1'b1;
    step();
    v4 = 1'b0;
    chk("ar_first_valid", vld4, 1'b1);
    chk("ar_first_data", do4, 8'h77);
    chk("ar_first_count", cnt4, 3'd1);
    r4 = 1'b1;
    step();
    chk("ar_final_empty", vld4, 1'b0);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
